heichips25_accum_alu: RTL and testbench

- Parametrised successor to the team's combinational pin-adder tile: a command-driven accumulator ALU behind the standard tile pin set.
- Host drives an 8-bit operand on ui_in and a 3-bit opcode plus strobe on uio_in[3:0].
- The block executes ADD/SUB/LOAD/CLR/SHL, a multi-cycle shift-add MUL, and byte-select readout of a wide accumulator.
- Status flags are driven on uio[7:4].

---
 rtl/heichips25_accum_alu.sv | 186 ++++++++++++++++++
 tb/tb_heichips25_accum_alu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/heichips25_accum_alu.sv
// heichips25_accum_alu: command-driven accumulator ALU behind the tile pin set.
// The host strobes uio_in[3] with an opcode on uio_in[2:0] and an operand on ui_in.
// The strobe is synchronised and edge-detected before a command is accepted.
// ADD/SUB/LOAD/CLR/SEL/SHL take one EXEC cycle. MUL is an 8-cycle shift-add.
// Optional macro ACCUM_SATURATE_EN: an overflowing op clamps its result instead
// of wrapping, and ovf is still set.
module heichips25_accum_alu #(
    parameter int ACC_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int         NB     = ACC_W / 8;
    localparam int         PW     = ACC_W + 8;
    localparam logic [5:0] ACC_W6 = 6'(ACC_W);
    localparam logic [2:0] NB3    = 3'(NB);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q, prime_q;
    logic                   hist_q, synced, pulse, busy;
    logic [ACC_W-1:0]       acc_q, a_ext, exec_acc, mul_res;
    logic [1:0]             sel_q, exec_sel;
    logic                   ovf_q, exec_ovf, mul_big;
    logic [2:0]             op_q, cnt_q;
    logic [7:0]             a_q, mplier_q;
    logic [PW-1:0]          prod_q, mcand_q, mul_sum;
    logic [ACC_W:0]         add_w, sub_w;
    logic [2*ACC_W-1:0]     shl_w;
    logic                   shl_big, shl_lost;
    logic                   unused_pins;

    assign unused_pins = ^uio_in[7:4];

    assign synced = sync_q[SYNC_STAGES-1];
    assign pulse  = synced & ~hist_q & ena & (state == S_IDLE);

    // Strobe synchroniser and edge history.
    // The history flop is held at 1 until the chain has filled with real
    // samples. This stops a strobe held high through reset from firing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prime_q <= '0;
            hist_q  <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], uio_in[3]};
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            hist_q  <= (&prime_q) ? synced : 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (pulse) state_nxt = (uio_in[2:0] == 3'd4) ? S_MUL : S_EXEC;
            S_EXEC:  state_nxt = S_IDLE;
            S_MUL:   if (cnt_q == 3'd7) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == S_MUL);
    end

    // Shared arithmetic on the captured operand
    always_comb begin
        a_ext    = ACC_W'(a_q);
        add_w    = {1'b0, acc_q} + {1'b0, a_ext};
        sub_w    = {1'b0, acc_q} - {1'b0, a_ext};
        shl_w    = {{ACC_W{1'b0}}, acc_q} << a_q[4:0];
        shl_big  = {1'b0, a_q[4:0]} >= ACC_W6;
        shl_lost = shl_big ? (|acc_q) : (|shl_w[2*ACC_W-1:ACC_W]);
        mul_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
        mul_big  = |mul_sum[PW-1:ACC_W];
`ifdef ACCUM_SATURATE_EN
        mul_res  = mul_big ? '1 : mul_sum[ACC_W-1:0];
`else
        mul_res  = mul_sum[ACC_W-1:0];
`endif
    end

    // Single-cycle op results, applied in EXEC
    always_comb begin
        exec_acc = acc_q;
        exec_ovf = ovf_q;
        exec_sel = sel_q;
        unique case (op_q)
            3'd1: begin exec_acc = a_ext; exec_ovf = 1'b0; end
            3'd2: begin
                exec_acc = add_w[ACC_W-1:0];
                exec_ovf = ovf_q | add_w[ACC_W];
`ifdef ACCUM_SATURATE_EN
                if (add_w[ACC_W]) exec_acc = '1;
`endif
            end
            3'd3: begin
                exec_acc = sub_w[ACC_W-1:0];
                exec_ovf = ovf_q | sub_w[ACC_W];
`ifdef ACCUM_SATURATE_EN
                if (sub_w[ACC_W]) exec_acc = '0;
`endif
            end
            3'd5: begin exec_acc = '0; exec_ovf = 1'b0; end
            3'd6: if ({1'b0, a_q[1:0]} < NB3) exec_sel = a_q[1:0];
            3'd7: begin
                exec_acc = shl_big ? '0 : shl_w[ACC_W-1:0];
                exec_ovf = ovf_q | shl_lost;
`ifdef ACCUM_SATURATE_EN
                if (shl_lost) exec_acc = '1;
`endif
            end
            default: ;
        endcase
    end

    // Datapath: capture on the pulse, commit in EXEC or on the last MUL step.
    // The multiplicand shifts left one place per cycle and is added to the
    // product when the current multiplier bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            sel_q    <= '0;
            ovf_q    <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (pulse) begin
                op_q     <= uio_in[2:0];
                a_q      <= ui_in;
                prod_q   <= '0;
                mcand_q  <= PW'(acc_q);
                mplier_q <= ui_in;
                cnt_q    <= '0;
            end
            if (state == S_EXEC) begin
                acc_q <= exec_acc;
                ovf_q <= exec_ovf;
                sel_q <= exec_sel;
            end
            if (state == S_MUL) begin
                prod_q   <= mul_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    acc_q <= mul_res;
                    ovf_q <= ovf_q | mul_big;
                end
            end
        end
    end

    // Byte readout from the registered accumulator
    always_comb begin
        uo_out = '0;
        for (int i = 0; i < NB; i++)
            if (sel_q == i[1:0]) uo_out = acc_q[8*i +: 8];
    end

    assign uio_out = {busy, ovf_q, (acc_q == '0), acc_q[ACC_W-1], 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_heichips25_accum_alu.sv
// Self-checking bench for heichips25_accum_alu (ACC_W=16, SYNC_STAGES=2).
// It uses directed vectors, hand-written multi-cycle sequences, and random
// commands checked against an arithmetic model of the accumulator.
module tb_heichips25_accum_alu;

    localparam int     W = 16;
    localparam longint M = 64'd1 << W;
`ifdef ACCUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
    logic [7:0] ui_in = '0, uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;

    int     total = 0, bad = 0;
    longint m_acc = 0;
    int     m_sel = 0;
    bit     m_ovf = 1'b0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] uo;
        logic [7:0] fl;
    } vec_t;
    vec_t tbl[$];

    heichips25_accum_alu #(.ACC_W(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_acc = 0; m_sel = 0; m_ovf = 1'b0;
    endfunction

    // Accumulator behaviour expressed as plain arithmetic on integers
    function automatic void model(input int op, input int a);
        longint t;
        case (op)
            1: begin m_acc = a; m_ovf = 1'b0; end
            2, 4, 7: begin
                if (op == 2)      t = m_acc + a;
                else if (op == 4) t = m_acc * a;
                else              t = m_acc * (64'd1 << (a % 32));
                if (t >= M) m_ovf = 1'b1;
                m_acc = (SAT && t >= M) ? M - 1 : t % M;
            end
            3: begin
                if (a > m_acc) begin
                    m_ovf = 1'b1;
                    m_acc = SAT ? 0 : m_acc - a + M;
                end else m_acc = m_acc - a;
            end
            5: begin m_acc = 0; m_ovf = 1'b0; end
            6: if ((a % 4) < W / 8) m_sel = a % 4;
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] m_uo();
        return 8'((m_acc >> (8 * m_sel)) & 255);
    endfunction

    function automatic logic [7:0] m_flags();
        return {1'b0, m_ovf, (m_acc == 0), m_acc[W-1], 4'b0000};
    endfunction

    // Full strobe handshake: hold long enough for a MUL, then release
    task automatic cmd(input logic [2:0] op, input logic [7:0] a);
        @(posedge clk); #1;
        ui_in  = a;
        uio_in = {4'b0000, 1'b1, op};
        repeat (14) @(posedge clk);
        #1 uio_in[3] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        model(int'(op), int'(a));
    endtask

    task automatic check_model(input string name);
        @(negedge clk);
        check({name, "_uo"}, uo_out, m_uo());
        check({name, "_flags"}, uio_out, m_flags());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nb, cnt;
        bit  old_ok, seen;

        // ---- reset with strobe held high (an ADD that must never fire) ----
        uio_in = 8'h0A; ui_in = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio", uio_out, 8'h20);
        check("rst_oe", uio_oe, 8'hF0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("post_rst_uo", uo_out, 8'h00);
        check("post_rst_uio", uio_out, 8'h20);
        #1 uio_in = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("post_rst_drop_uio", uio_out, 8'h20);
        model_reset();

        // ---- directed vectors ----
        tbl.push_back('{3'd1, 8'h7F, 8'h7F, 8'h00});
        tbl.push_back('{3'd2, 8'h81, 8'h00, 8'h00});
        tbl.push_back('{3'd6, 8'h01, 8'h01, 8'h00});
        tbl.push_back('{3'd6, 8'h03, 8'h01, 8'h00});
        tbl.push_back('{3'd6, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{3'd1, 8'h05, 8'h05, 8'h00});
`ifdef ACCUM_SATURATE_EN
        tbl.push_back('{3'd3, 8'h06, 8'h00, 8'h60});
`else
        tbl.push_back('{3'd3, 8'h06, 8'hFF, 8'h50});
`endif
        tbl.push_back('{3'd5, 8'h00, 8'h00, 8'h20});
        tbl.push_back('{3'd1, 8'hFF, 8'hFF, 8'h00});
        tbl.push_back('{3'd4, 8'hFF, 8'h01, 8'h10});
        tbl.push_back('{3'd6, 8'h01, 8'hFE, 8'h10});
`ifdef ACCUM_SATURATE_EN
        tbl.push_back('{3'd4, 8'h02, 8'hFF, 8'h50});
        tbl.push_back('{3'd6, 8'h00, 8'hFF, 8'h50});
`else
        tbl.push_back('{3'd4, 8'h02, 8'hFC, 8'h50});
        tbl.push_back('{3'd6, 8'h00, 8'h02, 8'h50});
`endif
        tbl.push_back('{3'd5, 8'h00, 8'h00, 8'h20});
        tbl.push_back('{3'd1, 8'h3C, 8'h3C, 8'h00});
        tbl.push_back('{3'd7, 8'h02, 8'hF0, 8'h00});
`ifdef ACCUM_SATURATE_EN
        tbl.push_back('{3'd7, 8'h0C, 8'hFF, 8'h50});
        tbl.push_back('{3'd1, 8'h01, 8'h01, 8'h00});
        tbl.push_back('{3'd7, 8'h1F, 8'hFF, 8'h50});
        tbl.push_back('{3'd2, 8'hFF, 8'hFF, 8'h50});
`else
        tbl.push_back('{3'd7, 8'h0C, 8'h00, 8'h60});
        tbl.push_back('{3'd1, 8'h01, 8'h01, 8'h00});
        tbl.push_back('{3'd7, 8'h1F, 8'h00, 8'h60});
        tbl.push_back('{3'd2, 8'hFF, 8'hFF, 8'h40});
`endif
        tbl.push_back('{3'd1, 8'hFF, 8'hFF, 8'h00});

        foreach (tbl[i]) begin
            cmd(tbl[i].op, tbl[i].a);
            @(negedge clk);
            check($sformatf("vec%0d_uo", i), uo_out, tbl[i].uo);
            check($sformatf("vec%0d_flags", i), uio_out, tbl[i].fl);
        end

        // ---- MUL busy length and old-acc readout while busy ----
        cmd(3'd1, 8'hFF);
        check_model("ld_ff");
        @(posedge clk); #1 ui_in = 8'hFF; uio_in = 8'h0C;
        nb = 0; old_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (uio_out[7]) begin
                nb++;
                if (uo_out !== 8'hFF) old_ok = 1'b0;
            end
        end
        check("mul_busy_cycles", 8'(nb), 8'd8);
        check("mul_old_acc_shown", {7'b0, old_ok}, 8'd1);
        @(posedge clk); #1 uio_in[3] = 1'b0;
        repeat (5) @(posedge clk);
        #1 model(4, 255);
        check_model("mul_ff");
        check("mul_ff_const", uo_out, 8'h01);

        // ---- ADD strobed during MUL and a strobe with ena=0 are dropped ----
        @(posedge clk); #1 ui_in = 8'h01; uio_in = 8'h0C;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = uio_out[7];
        end
        check("mul1_started", {7'b0, seen}, 8'd1);
        @(posedge clk); #1 uio_in[3] = 1'b0;
        repeat (2) @(posedge clk);
        #1 uio_in = 8'h0A; ui_in = 8'h01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("add_edge_while_busy", {7'b0, uio_out[7]}, 8'd1);
        repeat (10) @(posedge clk);
        #1 uio_in[3] = 1'b0;
        repeat (5) @(posedge clk);
        #1 ena = 1'b0; uio_in = 8'h0A;
        repeat (6) @(posedge clk);
        #1 uio_in[3] = 1'b0;
        repeat (5) @(posedge clk);
        #1 ena = 1'b1;
        model(4, 1);
        check_model("drop");

        // ---- reset in the middle of a MUL ----
        cmd(3'd1, 8'h12);
        @(posedge clk); #1 ui_in = 8'h03; uio_in = 8'h0C;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 4; i++) begin
            @(negedge clk);
            if (uio_out[7]) cnt++;
        end
        check("mid_mul_reached", 8'(cnt), 8'd4);
        #1 rst_n = 1'b0; uio_in = 8'h00;
        #1;
        check("mid_rst_uo", uo_out, 8'h00);
        check("mid_rst_uio", uio_out, 8'h20);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        cmd(3'd1, 8'h3C);
        check_model("post_rst_ld");
        cmd(3'd7, 8'h02);
        check_model("post_rst_shl");
        check("post_rst_shl_const", uo_out, 8'hF0);

        // ---- random commands against the model ----
        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            logic [7:0] a;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom_range(0, 255));
            cmd(op, a);
            check_model($sformatf("rnd%0d_op%0d", i, op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
